// File: rtl/data_offload_sync_pkg.sv
// Shared types for the data offload read-side sync controller.
// State encoding and sync-mode codes used by every channel.
package data_offload_sync_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ARMED     = 3'd2,
    PLAY      = 3'd3,
    DONE      = 3'd4
  } doff_sync_state_t;

  localparam logic [1:0] SYNC_AUTO = 2'd0;
  localparam logic [1:0] SYNC_HW   = 2'd1;
  localparam logic [1:0] SYNC_SW   = 2'd2;

endpackage

// File: rtl/data_offload_sync_ch.sv
// One playback channel: FSM, read address counter
// and saturating sync-event counter.
module data_offload_sync_ch
  import data_offload_sync_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              oneshot,
  input  logic [1:0]        sync_mode,
  input  logic              resync,
  input  logic [ADDR_W-1:0] len,
  input  logic              sync_rise,
  input  logic              sync_sw,
  input  logic              wr_done,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  sync_cnt
);

  doff_sync_state_t  state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lost_q;
  logic              sync_ev;
  logic              at_end;

  always_comb begin
    sync_ev = 1'b1;
    unique case (sync_mode)
      SYNC_HW: sync_ev = sync_rise;
      SYNC_SW: sync_ev = sync_sw;
      default: sync_ev = 1'b1;
    endcase
  end

  assign at_end = (addr_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= WAIT_DATA;
        WAIT_DATA: if (wr_done) state_q <= ARMED;
        ARMED: begin
          if (sync_ev) begin
            state_q <= PLAY;
            addr_q  <= '0;
            len_q   <= len;
            lost_q  <= 1'b0;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
        end
        PLAY: begin
          // a buffer lost mid-pass still plays out, then refills
          if (!wr_done) lost_q <= 1'b1;
          if (rd_ready) begin
            if (!at_end) begin
              addr_q <= addr_q + 1'b1;
            end else begin
              addr_q <= '0;
              len_q  <= len;
              lost_q <= 1'b0;
              if (lost_q || !wr_done)
                state_q <= WAIT_DATA;
              else if (oneshot)
                state_q <= DONE;
              else if (resync &&
                       (sync_mode == SYNC_HW ||
                        sync_mode == SYNC_SW))
                state_q <= ARMED;
            end
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_valid = (state_q == PLAY);
  assign rd_addr  = addr_q;
  assign rd_last  = rd_valid & at_end;
  assign state_o  = state_q;
  assign sync_cnt = cnt_q;

endmodule

// File: rtl/data_offload_multi_sync_ctrl.sv
// Multi-channel read-side playback/sync controller.
// Shared sync_ext edge detector feeding independent channels.
module data_offload_multi_sync_ctrl
  import data_offload_sync_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        cfg_enable,
  input  logic [NUM_CH-1:0]        cfg_oneshot,
  input  logic [2*NUM_CH-1:0]      cfg_sync_mode,
  input  logic [NUM_CH-1:0]        cfg_resync,
  input  logic [ADDR_W*NUM_CH-1:0] cfg_len,
  input  logic                     sync_ext,
  input  logic [NUM_CH-1:0]        sync_sw,
  input  logic [NUM_CH-1:0]        wr_done,
  input  logic [NUM_CH-1:0]        rd_ready,
  output logic [NUM_CH-1:0]        rd_valid,
  output logic [ADDR_W*NUM_CH-1:0] rd_addr,
  output logic [NUM_CH-1:0]        rd_last,
  output logic [3*NUM_CH-1:0]      state_o,
  output logic [CNT_W*NUM_CH-1:0]  sync_cnt
);

  logic sync_ext_d;
  logic rise_q;

  // registered edge so one rise reaches every channel together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ext_d <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      sync_ext_d <= sync_ext;
      rise_q     <= sync_ext & ~sync_ext_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    data_offload_sync_ch #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (cfg_enable[i]),
      .oneshot  (cfg_oneshot[i]),
      .sync_mode(cfg_sync_mode[2*i +: 2]),
      .resync   (cfg_resync[i]),
      .len      (cfg_len[ADDR_W*i +: ADDR_W]),
      .sync_rise(rise_q),
      .sync_sw  (sync_sw[i]),
      .wr_done  (wr_done[i]),
      .rd_ready (rd_ready[i]),
      .rd_valid (rd_valid[i]),
      .rd_addr  (rd_addr[ADDR_W*i +: ADDR_W]),
      .rd_last  (rd_last[i]),
      .state_o  (state_o[3*i +: 3]),
      .sync_cnt (sync_cnt[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_data_offload_multi_sync_ctrl.sv
// Directed bench for data_offload_multi_sync_ctrl.
// Hand-computed expectations, one check task.
module tb_data_offload_multi_sync_ctrl;

  localparam int NCH = 4;
  localparam int AW  = 10;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    cfg_enable = '0;
  logic [NCH-1:0]    cfg_oneshot = '0;
  logic [2*NCH-1:0]  cfg_sync_mode = '0;
  logic [NCH-1:0]    cfg_resync = '0;
  logic [AW*NCH-1:0] cfg_len = '0;
  logic              sync_ext = 1'b0;
  logic [NCH-1:0]    sync_sw = '0;
  logic [NCH-1:0]    wr_done = '1;
  logic [NCH-1:0]    rd_ready = '1;
  logic [NCH-1:0]    rd_valid;
  logic [AW*NCH-1:0] rd_addr;
  logic [NCH-1:0]    rd_last;
  logic [3*NCH-1:0]  state_o;
  logic [CW*NCH-1:0] sync_cnt;

  int n_chk = 0;
  int n_err = 0;

  data_offload_multi_sync_ctrl #(
    .NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable),
    .cfg_oneshot(cfg_oneshot),
    .cfg_sync_mode(cfg_sync_mode),
    .cfg_resync(cfg_resync),
    .cfg_len(cfg_len),
    .sync_ext(sync_ext),
    .sync_sw(sync_sw),
    .wr_done(wr_done),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_addr(rd_addr),
    .rd_last(rd_last),
    .state_o(state_o),
    .sync_cnt(sync_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cfg_enable = '0; cfg_oneshot = '0;
    cfg_sync_mode = '0; cfg_resync = '0;
    cfg_len = '0; sync_ext = 1'b0;
    sync_sw = '0; wr_done = '1; rd_ready = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] st(input int i);
    return 32'(state_o[3*i +: 3]);
  endfunction
  function automatic logic [31:0] ad(input int i);
    return 32'(rd_addr[AW*i +: AW]);
  endfunction
  function automatic logic [31:0] sc(input int i);
    return 32'(sync_cnt[CW*i +: CW]);
  endfunction

  initial begin
    int beats, lasts, acc, prev_a;
    bit stall;

    // reset state
    tick();
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_cnt", 32'(sync_cnt[31:0]), 0);
    check("rst_addr", 32'(rd_addr[31:0]), 0);
    check("rst_last", 32'(rd_last), 0);
    do_reset();

    // auto, oneshot, len 7 on ch0
    cfg_len[0 +: AW] = 10'd7;
    cfg_oneshot[0] = 1'b1;
    cfg_enable[0] = 1'b1;
    tick(); check("t1_wait", st(0), 1);
    tick(); check("t1_armed", st(0), 2);
    tick(); check("t1_play", st(0), 3);
    beats = 0; lasts = 0;
    for (int c = 0; c < 20; c++) begin
      if (rd_valid[0]) begin
        check("t1_addr", ad(0), 32'(beats));
        if (rd_last[0]) begin
          lasts++;
          check("t1_last_addr", ad(0), 7);
        end
        beats++;
      end
      tick();
    end
    check("t1_beats", 32'(beats), 8);
    check("t1_lasts", 32'(lasts), 1);
    check("t1_done", st(0), 4);
    check("t1_cnt", sc(0), 1);
    cfg_enable[0] = 1'b0;
    tick();
    check("t1_idle", st(0), 0);
    check("t1_cnt_keep", sc(0), 1);

    // hw, cyclic, len 3, all channels, 2-clk pulse
    do_reset();
    cfg_sync_mode = 8'b01_01_01_01;
    cfg_len = {10'd3, 10'd3, 10'd3, 10'd3};
    cfg_enable = '1;
    tick(); tick(); tick();
    check("t2_armed", 32'(state_o), 32'h492);
    sync_ext = 1'b1;
    tick();
    check("t2_lat", 32'(rd_valid), 0);
    tick();
    sync_ext = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("t2_valid", 32'(rd_valid), 32'hf);
      check("t2_addr0", ad(0), 32'(k % 4));
      check("t2_addr3", ad(3), 32'(k % 4));
      tick();
    end
    for (int i = 0; i < NCH; i++)
      check("t2_cnt", sc(i), 1);

    // hw, cyclic, resync, len 1 on ch0
    do_reset();
    cfg_sync_mode[1:0] = 2'd1;
    cfg_resync[0] = 1'b1;
    cfg_len[0 +: AW] = 10'd1;
    cfg_enable[0] = 1'b1;
    tick(); tick();
    for (int p = 0; p < 4; p++) begin
      check("t3_armed", st(0), 2);
      sync_ext = 1'b1;
      tick();
      sync_ext = 1'b0;
      tick();
      check("t3_play", st(0), 3);
      check("t3_a0", ad(0), 0);
      tick();
      check("t3_a1", ad(0), 1);
      check("t3_last", 32'(rd_last[0]), 1);
      tick();
      check("t3_rearm", st(0), 2);
      tick();
    end
    check("t3_cnt", sc(0), 4);

    // backpressure on ch1, oneshot len 3
    do_reset();
    cfg_len[AW +: AW] = 10'd3;
    cfg_oneshot[1] = 1'b1;
    cfg_enable[1] = 1'b1;
    tick(); tick(); tick();
    acc = 0; stall = 0; prev_a = 0;
    for (int c = 0; c < 40; c++) begin
      if (stall) check("t4_hold", ad(1), 32'(prev_a));
      rd_ready[1] = c[0];
      #1;
      stall = rd_valid[1] & ~rd_ready[1];
      prev_a = int'(ad(1));
      if (rd_valid[1] && rd_ready[1]) begin
        check("t4_addr", ad(1), 32'(acc));
        acc++;
      end
      tick();
    end
    check("t4_beats", 32'(acc), 4);
    check("t4_done", st(1), 4);

    // sw mode on ch2, hw on ch0
    do_reset();
    cfg_sync_mode = 8'b00_10_00_01;
    cfg_len = {10'd3, 10'd3, 10'd3, 10'd3};
    cfg_enable = 4'b0101;
    tick(); tick();
    sync_ext = 1'b1;
    tick();
    sync_ext = 1'b0;
    tick();
    check("t5_ch0_play", st(0), 3);
    check("t5_ch2_armed", st(2), 2);
    sync_sw[2] = 1'b1;
    tick();
    sync_sw[2] = 1'b0;
    check("t5_ch2_play", st(2), 3);
    check("t5_ch2_a0", ad(2), 0);
    check("t5_ch1_idle", st(1), 0);
    sync_sw[2] = 1'b1;
    tick();
    sync_sw[2] = 1'b0;
    tick();
    check("t5_ch2_cnt", sc(2), 1);
    check("t5_ch0_cnt", sc(0), 1);

    // wr_done drop on ch3 mid-pass
    do_reset();
    cfg_len[3*AW +: AW] = 10'd3;
    cfg_enable[3] = 1'b1;
    tick(); tick(); tick();
    tick();
    check("t6_a1", ad(3), 1);
    wr_done[3] = 1'b0;
    tick();
    wr_done[3] = 1'b1;
    tick();
    check("t6_a3", ad(3), 3);
    tick();
    check("t6_refill", st(3), 1);

    // enable drop at addr 5
    do_reset();
    cfg_len[0 +: AW] = 10'd7;
    cfg_enable[0] = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) tick();
    check("t7_a5", ad(0), 5);
    cfg_enable[0] = 1'b0;
    tick();
    check("t7_idle", st(0), 0);
    check("t7_valid", 32'(rd_valid[0]), 0);
    check("t7_cnt", sc(0), 1);

    // async reset mid-play
    cfg_enable[0] = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("t8_play", st(0), 3);
    #2;
    rst = 1'b1;
    #1;
    check("t8_valid", 32'(rd_valid), 0);
    check("t8_state", 32'(state_o), 0);
    check("t8_addr", 32'(rd_addr[31:0]), 0);
    check("t8_last", 32'(rd_last), 0);
    check("t8_cnt", sc(0), 0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
